// File: rtl/axi_rd_arbiter_if.sv
// Bundle of requester-side and slave-side AXI read signals shared by the arbiter.
// The master modport is the arbiter's view; the slave modport is its environment.
interface axi_rd_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]          req_arlen;
    logic [NUM_REQ*3-1:0]          req_arsize;
    logic [NUM_REQ*2-1:0]          req_arburst;
    logic [NUM_REQ-1:0]            req_arvalid;
    logic [NUM_REQ-1:0]            req_arready;
    logic [DATA_WIDTH-1:0]         req_rdata;
    logic [NUM_REQ-1:0]            req_rvalid;
    logic [NUM_REQ-1:0]            req_rready;

    logic [ADDR_WIDTH-1:0]         m_axi_araddr;
    logic [7:0]                    m_axi_arlen;
    logic [2:0]                    m_axi_arsize;
    logic [1:0]                    m_axi_arburst;
    logic                          m_axi_arvalid;
    logic                          m_axi_arready;
    logic [DATA_WIDTH-1:0]         m_axi_rdata;
    logic                          m_axi_rvalid;
    logic                          m_axi_rready;

    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    modport master (
        input  req_araddr, req_arlen, req_arsize, req_arburst, req_arvalid, req_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rvalid,
        output req_arready, req_rdata, req_rvalid,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
        output grant, busy
    );

    modport slave (
        output req_araddr, req_arlen, req_arsize, req_arburst, req_arvalid, req_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rvalid,
        input  req_arready, req_rdata, req_rvalid,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
        input  grant, busy
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between NUM_REQ burst readers,
// one burst at a time: arbitrate, forward AR, then route arlen+1 R beats back.
//
// state | meaning
// IDLE  | no owner; arbitrate among raised req_arvalid
// ADDR  | granted AR presented to the slave until m_axi_arready
// DATA  | R beats routed to the owner until the last one transfers
module axi_rd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    axi_rd_arbiter_if.master  bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant, grant_nxt;
    logic [IW-1:0]      gidx, gidx_nxt;
    logic [IW-1:0]      last_grant, last_grant_nxt;
    logic [7:0]         beats_left, beats_left_nxt;
    logic [IW-1:0]      pick;
    logic               pick_ok;

    logic [ADDR_WIDTH-1:0] araddr_a  [NUM_REQ];
    logic [7:0]            arlen_a   [NUM_REQ];
    logic [2:0]            arsize_a  [NUM_REQ];
    logic [1:0]            arburst_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign araddr_a[i]  = bus.req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign arlen_a[i]   = bus.req_arlen[i*8 +: 8];
        assign arsize_a[i]  = bus.req_arsize[i*3 +: 3];
        assign arburst_a[i] = bus.req_arburst[i*2 +: 2];
    end

    // Closest raised request after last_grant, measured as distance modulo NUM_REQ.
    always_comb begin
        int d;
        int best;
        d       = 0;
        best    = NUM_REQ + 1;
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i > int'(last_grant)) ? i - int'(last_grant) : i - int'(last_grant) + NUM_REQ;
            if (bus.req_arvalid[i] && d < best) begin
                best    = d;
                pick    = IW'(i);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            gidx       <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            beats_left <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            gidx       <= gidx_nxt;
            last_grant <= last_grant_nxt;
            beats_left <= beats_left_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant;
        gidx_nxt           = gidx;
        last_grant_nxt     = last_grant;
        beats_left_nxt     = beats_left;
        bus.m_axi_araddr   = '0;
        bus.m_axi_arlen    = '0;
        bus.m_axi_arsize   = '0;
        bus.m_axi_arburst  = '0;
        bus.m_axi_arvalid  = 1'b0;
        bus.m_axi_rready   = 1'b0;
        bus.req_arready    = '0;
        bus.req_rvalid     = '0;
        bus.req_rdata      = '0;
        unique case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_nxt = ADDR;
                    gidx_nxt  = pick;
                    grant_nxt = NUM_REQ'(1) << pick;
                end
            end
            ADDR: begin
                bus.m_axi_araddr      = araddr_a[gidx];
                bus.m_axi_arlen       = arlen_a[gidx];
                bus.m_axi_arsize      = arsize_a[gidx];
                bus.m_axi_arburst     = arburst_a[gidx];
                bus.m_axi_arvalid     = 1'b1;
                bus.req_arready[gidx] = bus.m_axi_arready;
                if (bus.m_axi_arready) begin
                    beats_left_nxt = arlen_a[gidx];
                    state_nxt      = DATA;
                end
            end
            DATA: begin
                bus.req_rdata        = bus.m_axi_rdata;
                bus.req_rvalid[gidx] = bus.m_axi_rvalid;
                bus.m_axi_rready     = bus.req_rready[gidx];
                // beats_left counts beats after the current one, so 0 marks the last.
                if (bus.m_axi_rvalid && bus.req_rready[gidx]) begin
                    if (beats_left == 8'd0) begin
                        state_nxt      = IDLE;
                        last_grant_nxt = gidx;
                        grant_nxt      = '0;
                    end else begin
                        beats_left_nxt = beats_left - 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.grant = grant;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: bench-side requesters and slave, a
// transaction-level reference model checked every cycle, plus directed scenarios.
module tb_axi_rd_arbiter;
    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_rd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int tests = 0;
    int fails = 0;

    // requester-side stimulus state
    bit [NR-1:0]   pend = '0;
    bit [NR-1:0]   hold = '0;
    bit [NR-1:0]   ar_hs = '0;
    bit [NR-1:0]   rr = '0;
    logic [AW-1:0] p_addr  [NR];
    logic [7:0]    p_len   [NR];
    logic [2:0]    p_size  [NR];
    logic [1:0]    p_burst [NR];

    // knobs
    int req_prob = 0, max_len = 0, arready_pct = 100, rvalid_pct = 100;
    int rready_pct = 100, junk_pct = 0, stall_left = 0;
    bit rv_alt = 0, rv_tog = 0, bp_mode = 0, drop2 = 0, drop5 = 0;
    bit fixed_base_en = 0;
    logic [DW-1:0] fixed_base = '0;

    // slave model
    bit            s_active = 0;
    int            s_idx = 0;
    logic [DW-1:0] s_base = '0;

    // reference model: owner of the port, AR still pending, beats still owed
    int m_owner = -1;
    bit m_addr_ph = 0;
    int m_rem = 0;
    int m_last = NR - 1;

    // observation logs
    int            grant_log[$];
    logic [DW-1:0] rx_data[$];
    int            rx_who[$];
    int arv_cycles = 0, addr_changes = 0, arrdy_pulses = 0, rv1_seen = 0;
    bit arv_prev = 0;
    logic [AW-1:0] arv_prev_addr = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit pct(int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    task automatic pack();
        for (int i = 0; i < NR; i++) begin
            bus.req_araddr[i*AW +: AW] = p_addr[i];
            bus.req_arlen[i*8 +: 8]    = p_len[i];
            bus.req_arsize[i*3 +: 3]   = p_size[i];
            bus.req_arburst[i*2 +: 2]  = p_burst[i];
        end
        bus.req_arvalid = pend;
        bus.req_rready  = rr;
    endtask

    task automatic new_req(int i);
        pend[i]    = 1'b1;
        p_addr[i]  = AW'($urandom);
        p_len[i]   = 8'($urandom_range(0, max_len));
        p_size[i]  = 3'($urandom);
        p_burst[i] = 2'($urandom_range(0, 2));
    endtask

    task automatic issue(int i, logic [AW-1:0] a, logic [7:0] len);
        pend[i]    = 1'b1;
        p_addr[i]  = a;
        p_len[i]   = len;
        p_size[i]  = 3'd2;
        p_burst[i] = 2'd1;
        pack();
    endtask

    task automatic drive();
        int n;
        for (int i = 0; i < NR; i++) begin
            if (ar_hs[i]) begin
                ar_hs[i] = 1'b0;
                pend[i]  = 1'b0;
            end
            rr[i] = pct(rready_pct);
            if (!pend[i] && (hold[i] || pct(req_prob))) new_req(i);
        end
        if (bp_mode) begin
            n = rx_data.size();
            rr[0] = 1'b1;
            if (n == 2 && !drop2) begin rr[0] = 1'b0; drop2 = 1; end
            if (n == 5 && !drop5) begin rr[0] = 1'b0; drop5 = 1; end
        end
        if (stall_left > 0) begin
            bus.m_axi_arready = 1'b0;
            stall_left--;
        end else begin
            bus.m_axi_arready = pct(arready_pct);
        end
        if (s_active) begin
            if (rv_alt) begin
                rv_tog = ~rv_tog;
                bus.m_axi_rvalid = rv_tog;
            end else begin
                bus.m_axi_rvalid = pct(rvalid_pct);
            end
            bus.m_axi_rdata = s_base + DW'(s_idx);
        end else begin
            bus.m_axi_rvalid = pct(junk_pct);
            bus.m_axi_rdata  = DW'($urandom);
        end
        pack();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_done(string name, int budget);
        int c = 0;
        while ((m_owner >= 0 || pend != '0) && c < budget) begin
            step();
            c++;
        end
        check(name, {63'd0, (m_owner < 0 && pend == '0)}, 64'd1);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rx_data.delete();
        rx_who.delete();
        arv_cycles = 0; addr_changes = 0; arrdy_pulses = 0; rv1_seen = 0;
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        pend = '0;
        for (int k = 0; k < 3; k++) step();
        clear_logs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive();
    endtask

    // compare process: expected outputs from the model, then advance the model
    logic [NR-1:0] e_grant, e_arready, e_rvalid;
    logic          e_arvalid, e_rready;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_len;
    logic [2:0]    e_size;
    logic [1:0]    e_burst;
    logic [DW-1:0] e_rdata;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_m_arvalid", bus.m_axi_arvalid, 0);
            check("rst_m_araddr", bus.m_axi_araddr, 0);
            check("rst_m_rready", bus.m_axi_rready, 0);
            check("rst_req_arready", bus.req_arready, 0);
            check("rst_req_rvalid", bus.req_rvalid, 0);
            check("rst_req_rdata", bus.req_rdata, 0);
            check("rst_grant", bus.grant, 0);
            check("rst_busy", bus.busy, 0);
            m_owner = -1; m_addr_ph = 0; m_rem = 0; m_last = NR - 1;
            s_active = 0; ar_hs = '0;
        end else begin
            e_grant = '0; e_arready = '0; e_rvalid = '0; e_arvalid = 0; e_rready = 0;
            e_addr = '0; e_len = '0; e_size = '0; e_burst = '0; e_rdata = '0;
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                if (m_addr_ph) begin
                    e_arvalid = 1'b1;
                    e_addr    = p_addr[m_owner];
                    e_len     = p_len[m_owner];
                    e_size    = p_size[m_owner];
                    e_burst   = p_burst[m_owner];
                    e_arready[m_owner] = bus.m_axi_arready;
                end else begin
                    e_rdata = bus.m_axi_rdata;
                    e_rvalid[m_owner] = bus.m_axi_rvalid;
                    e_rready = bus.req_rready[m_owner];
                end
            end
            check("grant", bus.grant, e_grant);
            check("busy", bus.busy, m_owner >= 0);
            check("m_arvalid", bus.m_axi_arvalid, e_arvalid);
            check("m_araddr", bus.m_axi_araddr, e_addr);
            check("m_arlen", bus.m_axi_arlen, e_len);
            check("m_arsize", bus.m_axi_arsize, e_size);
            check("m_arburst", bus.m_axi_arburst, e_burst);
            check("req_arready", bus.req_arready, e_arready);
            check("req_rvalid", bus.req_rvalid, e_rvalid);
            check("m_rready", bus.m_axi_rready, e_rready);
            check("req_rdata", bus.req_rdata, e_rdata);

            if (bus.m_axi_arvalid) begin
                arv_cycles++;
                if (arv_prev && bus.m_axi_araddr != arv_prev_addr) addr_changes++;
            end
            arv_prev = bus.m_axi_arvalid;
            arv_prev_addr = bus.m_axi_araddr;
            if (bus.req_arready != '0) arrdy_pulses++;
            if (bus.req_rvalid[1]) rv1_seen++;

            if (m_owner < 0) begin
                for (int k = NR; k >= 1; k--) begin
                    if (bus.req_arvalid[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
                end
                m_addr_ph = (m_owner >= 0);
            end else if (m_addr_ph) begin
                if (bus.m_axi_arready) begin
                    m_addr_ph = 0;
                    m_rem = int'(p_len[m_owner]) + 1;
                    ar_hs[m_owner] = 1'b1;
                    grant_log.push_back(m_owner);
                    s_active = 1;
                    s_idx = 0;
                    s_base = fixed_base_en ? fixed_base : DW'($urandom);
                end
            end else if (bus.m_axi_rvalid && bus.req_rready[m_owner]) begin
                rx_data.push_back(bus.req_rdata);
                rx_who.push_back(m_owner);
                s_idx++;
                m_rem--;
                if (m_rem == 0) begin
                    m_last = m_owner;
                    m_owner = -1;
                    s_active = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int bad;
        for (int i = 0; i < NR; i++) begin
            p_addr[i] = '0; p_len[i] = '0; p_size[i] = '0; p_burst[i] = '0;
        end
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        pack();

        // reset state
        do_reset();
        step();
        check("post_rst_grant", bus.grant, 0);
        check("post_rst_busy", bus.busy, 0);

        // single request, requester 0
        fixed_base_en = 1; fixed_base = 32'hA0;
        clear_logs();
        issue(0, 16'h0100, 8'd3);
        step();
        check("ar_latency", bus.m_axi_arvalid, 1);
        check("ar_addr", bus.m_axi_araddr, 16'h0100);
        wait_done("single_done", 30);
        check("single_beats", rx_data.size(), 4);
        for (int k = 0; k < rx_data.size() && k < 4; k++) begin
            check("single_data", rx_data[k], 32'hA0 + k);
            check("single_who", rx_who[k], 0);
        end
        check("single_grant_end", bus.grant, 0);
        check("single_rv1", rv1_seen, 0);

        // contention from reset release
        hold = 3'b011; max_len = 0;
        do_reset();
        c = 0;
        while (grant_log.size() < 4 && c < 80) begin step(); c++; end
        check("contention_count", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            check("contention_g0", grant_log[0], 0);
            check("contention_g1", grant_log[1], 1);
            check("contention_g2", grant_log[2], 0);
            check("contention_g3", grant_log[3], 1);
        end
        hold = '0;
        wait_done("contention_drain", 100);

        // backpressure: rvalid every other cycle, rready dropped on beats 2 and 5
        fixed_base = 32'h10; rv_alt = 1; bp_mode = 1; drop2 = 0; drop5 = 0;
        clear_logs();
        issue(0, 16'h0200, 8'd7);
        wait_done("bp_done", 80);
        check("bp_beats", rx_data.size(), 8);
        bad = 0;
        for (int k = 0; k < rx_data.size(); k++) if (rx_data[k] !== 32'h10 + k) bad++;
        check("bp_seq", bad, 0);
        check("bp_drops", {drop5, drop2}, 2'b11);
        rv_alt = 0; bp_mode = 0;

        // AR stall of 10 cycles
        clear_logs();
        issue(1, 16'h3344, 8'd0);
        stall_left = 10;
        wait_done("stall_done", 40);
        check("stall_arvalid_cycles", arv_cycles, 11);
        check("stall_addr_stable", addr_changes, 0);
        check("stall_arready_pulses", arrdy_pulses, 1);

        // max burst
        fixed_base = 32'h0;
        clear_logs();
        issue(2, 16'h0000, 8'd255);
        wait_done("max_done", 400);
        check("max_beats", rx_data.size(), 256);
        bad = 0;
        for (int k = 0; k < rx_data.size(); k++) if (rx_data[k] !== 32'(k) || rx_who[k] != 2) bad++;
        check("max_seq", bad, 0);
        step();
        check("max_idle_busy", bus.busy, 0);

        // reset mid-DATA with five beats still owed after the current one
        clear_logs();
        issue(0, 16'h0040, 8'd7);
        c = 0;
        while (rx_data.size() < 2 && c < 30) begin step(); c++; end
        check("mid_two_beats", rx_data.size(), 2);
        rst = 1'b0;
        #1;
        check("mid_rst_arvalid", bus.m_axi_arvalid, 0);
        check("mid_rst_rvalid", bus.req_rvalid, 0);
        check("mid_rst_rready", bus.m_axi_rready, 0);
        check("mid_rst_rdata", bus.req_rdata, 0);
        check("mid_rst_grant", bus.grant, 0);
        check("mid_rst_busy", bus.busy, 0);
        pend = '0;
        for (int k = 0; k < 3; k++) step();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive();
        step();
        check("mid_after_grant", bus.grant, 0);
        check("mid_after_busy", bus.busy, 0);

        // randomized traffic
        fixed_base_en = 0;
        req_prob = 30; max_len = 7; arready_pct = 70; rvalid_pct = 70;
        rready_pct = 80; junk_pct = 30;
        clear_logs();
        for (int k = 0; k < 3000; k++) begin
            max_len = (k % 500 < 50) ? 40 : 7;
            step();
        end
        req_prob = 0;
        wait_done("random_drain", 3000);
        check("random_activity", grant_log.size() > 50, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
